i2c_cam_target: RTL

I2C_CAM_TARGET -- requirements
Module: i2c_cam_target

---
 rtl/top_pkg.sv | 33 +++
 rtl/i2c_line_cond.sv | 72 +++++++
 rtl/i2c_cam_target.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/top_pkg.sv
// -----------------------------------------------------------------------------
// top_pkg
// Shared definitions for the I2C register-access target:
//   - i2c_state_t : protocol FSM state encoding
//   - ACK / NACK  : I2C acknowledge bit levels
//   - ptr_inc     : register pointer increment (wraps 16'hFFFF -> 16'h0000)
// -----------------------------------------------------------------------------
package top_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DEVADDR  = 4'd1,
    ST_ACK_DEV  = 4'd2,
    ST_RADDR_HI = 4'd3,
    ST_ACK_HI   = 4'd4,
    ST_RADDR_LO = 4'd5,
    ST_ACK_LO   = 4'd6,
    ST_WDATA    = 4'd7,
    ST_ACK_WR   = 4'd8,
    ST_RDATA    = 4'd9,
    ST_MACK     = 4'd10,
    ST_IGNORE   = 4'd11
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Natural 16-bit wrap is the intended behaviour at the top of the map.
  function automatic logic [15:0] ptr_inc(input logic [15:0] p);
    return p + 16'h0001;
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// -----------------------------------------------------------------------------
// i2c_line_cond
// Conditions the raw I2C lines: 2-FF synchronizer, GLITCH_CYC-sample filter,
// one-cycle SCL edge pulses and START/STOP detection on the filtered levels.
// Ports:
//   clk, reset         : system clock, async active-high reset
//   scl_in, sda_in     : raw bus levels
//   sda                : filtered SDA level
//   scl_rise, scl_fall : one-cycle pulses on filtered SCL edges
//   start_det          : filtered SDA fall while filtered SCL stays high
//   stop_det           : filtered SDA rise while filtered SCL stays high
// -----------------------------------------------------------------------------
module i2c_line_cond #(
  parameter int GLITCH_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  localparam int             CW   = (GLITCH_CYC > 2) ? $clog2(GLITCH_CYC) : 1;
  localparam logic [CW-1:0]  CMAX = CW'(GLITCH_CYC - 1);

  // Index 1 = SCL, index 0 = SDA.
  logic [1:0]    meta;
  logic [1:0]    sync;
  logic [1:0]    filt;
  logic [1:0]    prev;
  logic [CW-1:0] cnt [2];

  // Synchronize, then accept a new level only after GLITCH_CYC consecutive
  // differing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 2'b11;
      sync   <= 2'b11;
      filt   <= 2'b11;
      prev   <= 2'b11;
      cnt[0] <= {CW{1'b0}};
      cnt[1] <= {CW{1'b0}};
    end else begin
      meta <= {scl_in, sda_in};
      sync <= meta;
      prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == filt[i]) begin
          cnt[i] <= {CW{1'b0}};
        end else if (cnt[i] == CMAX) begin
          filt[i] <= sync[i];
          cnt[i]  <= {CW{1'b0}};
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign sda       = filt[0];
  assign scl_rise  =  filt[1] & ~prev[1];
  assign scl_fall  = ~filt[1] &  prev[1];
  // SCL must be high both before and after the SDA edge to count as a
  // bus condition rather than data changing around an SCL edge.
  assign start_det = ~filt[0] &  prev[0] & filt[1] & prev[1];
  assign stop_det  =  filt[0] & ~prev[0] & filt[1] & prev[1];

endmodule

// File: rtl/i2c_cam_target.sv
// -----------------------------------------------------------------------------
// i2c_cam_target
// I2C target giving an initiator access to a 16-bit addressed byte register
// space (camera-style: dev addr, 16-bit pointer, then data bytes).
// Ports:
//   clk, reset          : 100MHz system clock, async active-high reset
//   i2c_scl             : bus clock from the initiator (never stretched)
//   i2c_sda             : open-drain data, driven 0 or released
//   reg_addr            : register pointer
//   reg_we / reg_wdata  : one-cycle write strobe and its data
//   reg_re / reg_rdata  : one-cycle read strobe; data sampled 1 clk later
//   busy                : high from START until STOP / return to IDLE
// -----------------------------------------------------------------------------
module i2c_cam_target
  import top_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h10,
  parameter int         GLITCH_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  output logic [15:0] reg_addr,
  output logic        reg_we,
  output logic [7:0]  reg_wdata,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  i2c_state_t state;
  i2c_state_t next;

  logic       sda;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  logic [2:0] bit_cnt;
  logic [6:0] shreg;      // bits already received of the current byte
  logic       rw;         // R/W bit of the last matched device address
  logic [7:0] hi_byte;    // pointer high byte held until the low byte lands
  logic [7:0] tx;         // outgoing read byte, MSB presented first
  logic       ack_phase;  // 9th SCL rise of the current ack bit has been seen
  logic       re_d;
  logic       sda_oe;

  logic [7:0] byte_in;
  logic       byte_done;
  logic       ack_done;

  i2c_line_cond #(.GLITCH_CYC(GLITCH_CYC)) u_line (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (i2c_scl),
    .sda_in    (i2c_sda),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign i2c_sda   = sda_oe ? 1'b0 : 1'bz;
  assign byte_in   = {shreg, sda};
  assign byte_done = scl_rise & (bit_cnt == 3'd7);
  // An ack slot ends on the SCL fall that follows its 9th rise.
  assign ack_done  = scl_fall & ack_phase;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next;
    end
  end

  // Next-state logic; bus conditions override every state.
  always_comb begin
    next = state;
    if (stop_det) begin
      next = ST_IDLE;
    end else if (start_det) begin
      next = ST_DEVADDR;
    end else begin
      case (state)
        ST_IDLE:     next = ST_IDLE;
        ST_DEVADDR: begin
          if (byte_done) begin
            if (byte_in[7:1] == DEV_ADDR) next = ST_ACK_DEV;
            else                          next = ST_IGNORE;
          end else begin
            next = ST_DEVADDR;
          end
        end
        ST_ACK_DEV: begin
          if (ack_done) begin
            if (rw) next = ST_RDATA;
            else    next = ST_RADDR_HI;
          end else begin
            next = ST_ACK_DEV;
          end
        end
        ST_RADDR_HI: next = byte_done ? ST_ACK_HI   : ST_RADDR_HI;
        ST_ACK_HI:   next = ack_done  ? ST_RADDR_LO : ST_ACK_HI;
        ST_RADDR_LO: next = byte_done ? ST_ACK_LO   : ST_RADDR_LO;
        ST_ACK_LO:   next = ack_done  ? ST_WDATA    : ST_ACK_LO;
        ST_WDATA:    next = byte_done ? ST_ACK_WR   : ST_WDATA;
        ST_ACK_WR:   next = ack_done  ? ST_WDATA    : ST_ACK_WR;
        ST_RDATA:    next = byte_done ? ST_MACK     : ST_RDATA;
        ST_MACK: begin
          if (scl_rise && (sda != ACK)) begin
            next = ST_IGNORE;
          end else if (ack_done) begin
            next = ST_RDATA;
          end else begin
            next = ST_MACK;
          end
        end
        ST_IGNORE:   next = ST_IGNORE;
        default:     next = ST_IDLE;
      endcase
    end
  end

  // Datapath: shifting, pointer, strobes and SDA drive (changed on SCL fall).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_addr  <= 16'h0000;
      reg_we    <= 1'b0;
      reg_wdata <= 8'h00;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      sda_oe    <= 1'b0;
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      rw        <= 1'b0;
      hi_byte   <= 8'h00;
      tx        <= 8'hFF;
      ack_phase <= 1'b0;
      re_d      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      re_d   <= reg_re;
      busy   <= (next != ST_IDLE);
      // Pointer advances only after the write strobe cycle, so reg_addr is
      // the written address while reg_we is high.
      if (reg_we) reg_addr <= ptr_inc(reg_addr);
      if (re_d)   tx       <= reg_rdata;

      if (start_det || stop_det) begin
        sda_oe    <= 1'b0;
        bit_cnt   <= 3'd0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          ST_DEVADDR, ST_RADDR_HI, ST_RADDR_LO, ST_WDATA: begin
            if (scl_rise) begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;   // wraps to 0 on the 8th bit
              if (bit_cnt == 3'd7) begin
                if (state == ST_DEVADDR)  rw       <= byte_in[0];
                if (state == ST_RADDR_HI) hi_byte  <= byte_in;
                if (state == ST_RADDR_LO) reg_addr <= {hi_byte, byte_in};
                if (state == ST_WDATA) begin
                  reg_we    <= 1'b1;
                  reg_wdata <= byte_in;
                end
              end
            end
          end
          ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_WR: begin
            if (scl_rise) begin
              ack_phase <= 1'b1;
              if ((state == ST_ACK_DEV) && rw) reg_re <= 1'b1;
            end else if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                // A read hands over straight from our ACK to the data MSB.
                if ((state == ST_ACK_DEV) && rw) begin
                  sda_oe <= ~tx[7];
                  tx     <= {tx[6:0], NACK};
                end else begin
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              sda_oe <= ~tx[7];
              tx     <= {tx[6:0], NACK};
            end
          end
          ST_MACK: begin
            if (scl_rise) begin
              if (sda == ACK) begin
                ack_phase <= 1'b1;
                reg_addr  <= ptr_inc(reg_addr);
                reg_re    <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
              end
            end else if (scl_fall) begin
              if (ack_phase) begin
                ack_phase <= 1'b0;
                sda_oe    <= ~tx[7];
                tx        <= {tx[6:0], NACK};
              end else begin
                sda_oe <= 1'b0;   // leave the ack slot to the initiator
              end
            end
          end
          ST_IDLE, ST_IGNORE: sda_oe <= 1'b0;
          default:            sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule
